// File: rtl/array_mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// array_mul_arbiter_pkg
//
// Purpose:
//   Shared definitions for the two-requester multiplier arbiter: the default
//   operand width, the controller state encoding and the round-robin winner
//   selection used when deciding which requester gets the shared multiplier.
//
// Contents:
//   k_default  default operand width in bits
//   state_t    controller states IDLE / CALC / RESP
//   rr_pick    returns the index of the requester that wins this cycle
// ---------------------------------------------------------------------------
package array_mul_arbiter_pkg;

  localparam int k_default = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Picks the winning requester index. When both are pending the priority
  // pointer decides; otherwise the single pending requester wins. With no
  // requester pending the result is don't-care and callers must gate it.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic ptr);
    if (v0 && v1) begin
      return ptr;
    end
    return v1;
  endfunction

endpackage

// File: rtl/array_mul_arbiter_array_mul.sv
// ---------------------------------------------------------------------------
// array_mul
//
// Purpose:
//   Purely combinational unsigned array multiplier. Each multiplier bit
//   gates a row of partial products; each row is added with a ripple-carry
//   chain to the shifted running sum of the row above. The lowest bit of
//   every row drops out as one product bit, and the final row supplies the
//   upper half of the product.
//
// Ports:
//   mul_cand  in   k   multiplicand, unsigned
//   mul_ier   in   k   multiplier, unsigned
//   result    out  2k  full-width product mul_cand * mul_ier
// ---------------------------------------------------------------------------
module array_mul
  import array_mul_arbiter_pkg::*;
#(
  parameter int k = k_default
) (
  input  logic [k-1:0]   mul_cand,
  input  logic [k-1:0]   mul_ier,
  output logic [2*k-1:0] result
);

  logic [k-1:0] low_bits;

  // One generate row per multiplier bit. Row 0 is just its partial product;
  // every later row adds its partial product to the previous row's sum
  // shifted down by one, with that row's carry-out entering at the top.
  for (genvar i = 0; i < k; i++) begin : g_row
    logic [k-1:0] pp;
    logic [k-1:0] sum;
    logic         cout;

    assign pp = mul_cand & {k{mul_ier[i]}};

    if (i == 0) begin : g_first
      assign sum  = pp;
      assign cout = 1'b0;
    end else begin : g_add
      logic [k-1:0] addend;

      assign addend = {g_row[i-1].cout, g_row[i-1].sum[k-1:1]};

      // Ripple-carry adder across the row, kept in one process so the
      // carry chain is evaluated in a single pass.
      always_comb begin
        logic c;
        c    = 1'b0;
        sum  = '0;
        for (int j = 0; j < k; j++) begin
          sum[j] = addend[j] ^ pp[j] ^ c;
          c      = (addend[j] & pp[j]) | (c & (addend[j] ^ pp[j]));
        end
        cout = c;
      end
    end

    assign low_bits[i] = sum[0];
  end

  // Product bits 0..k-1 come from the bottom bit of each row; the last row
  // contributes its remaining sum bits and its carry as the top half.
  assign result = {g_row[k-1].cout, g_row[k-1].sum[k-1:1], low_bits};

endmodule

// File: rtl/array_mul_arbiter.sv
// ---------------------------------------------------------------------------
// array_mul_arbiter
//
// Purpose:
//   Shares one array_mul between two requesters. A three-state controller
//   grants one requester in IDLE (round-robin when both are pending),
//   registers the product in CALC, and holds the response in RESP until the
//   consumer takes it. One transaction is in flight at a time.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req0_valid   in   1   requester 0 has operands pending
//   req0_a       in   k   requester 0 multiplicand
//   req0_x       in   k   requester 0 multiplier
//   req0_ready   out  1   requester 0 operands taken this cycle
//   req1_valid   in   1   requester 1 has operands pending
//   req1_a       in   k   requester 1 multiplicand
//   req1_x       in   k   requester 1 multiplier
//   req1_ready   out  1   requester 1 operands taken this cycle
//   rsp_valid    out  1   response presented
//   rsp_ready    in   1   consumer takes the response
//   rsp_result   out  2k  product of the owning requester's operands
//   rsp_id       out  1   index of the owning requester
//   busy         out  1   controller is not idle
// ---------------------------------------------------------------------------
module array_mul_arbiter
  import array_mul_arbiter_pkg::*;
#(
  parameter int k = k_default
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [k-1:0]   req0_a,
  input  logic [k-1:0]   req0_x,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [k-1:0]   req1_a,
  input  logic [k-1:0]   req1_x,
  output logic           req1_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*k-1:0] rsp_result,
  output logic           rsp_id,
  output logic           busy
);

  state_t         state;
  state_t         state_next;
  logic           ptr;
  logic [k-1:0]   op_a;
  logic [k-1:0]   op_x;
  logic           op_id;
  logic [2*k-1:0] product;
  logic           grant_id;
  logic           accept;

  // Decide who would win this cycle and whether a grant actually happens.
  // The grant is also gated by rst_n so that both ready outputs are forced
  // low for as long as reset is held, even though the state is already IDLE.
  always_comb begin
    grant_id = rr_pick(req0_valid, req1_valid, ptr);
    accept   = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a grant always moves to CALC, CALC always lasts one
  // cycle, and RESP waits for the consumer. Returning to IDLE on the
  // consuming edge is what keeps a new grant out of that same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
        end
      end
      CALC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode. Ready goes only to the winner and only while a grant is
  // happening, so the loser and every non-IDLE cycle see ready low.
  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
  end

  // Operand capture and round-robin pointer. The pointer moves to the other
  // requester after every grant, so contention alternates between them.
  // Inputs of the losing requester are never sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_x  <= '0;
      op_id <= 1'b0;
      ptr   <= 1'b0;
    end else if (accept) begin
      op_a  <= grant_id ? req1_a : req0_a;
      op_x  <= grant_id ? req1_x : req0_x;
      op_id <= grant_id;
      ptr   <= ~grant_id;
    end
  end

  // Response register: loaded once in CALC and then left alone, so the
  // presented result and id stay stable throughout RESP backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else if (state == CALC) begin
      rsp_result <= product;
      rsp_id     <= op_id;
    end
  end

  array_mul #(
    .k (k)
  ) u_array_mul (
    .mul_cand (op_a),
    .mul_ier  (op_x),
    .result   (product)
  );

endmodule

// File: tb/tb_array_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_array_mul_arbiter
//
// Directed bench for array_mul_arbiter. Expected responses (id, product)
// are computed by hand and queued when each request is issued; a separate
// monitor pops and compares whenever a response handshake happens.
// ---------------------------------------------------------------------------
module tb_array_mul_arbiter;

  localparam int K = 8;

  typedef struct packed {
    logic         id;
    logic [2*K-1:0] result;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req0_valid;
  logic [K-1:0]   req0_a;
  logic [K-1:0]   req0_x;
  logic           req0_ready;
  logic           req1_valid;
  logic [K-1:0]   req1_a;
  logic [K-1:0]   req1_x;
  logic           req1_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*K-1:0] rsp_result;
  logic           rsp_id;
  logic           busy;

  exp_t sbQ[$];
  int   nChecks   = 0;
  int   nErrors   = 0;
  int   respCount = 0;
  int   cycle     = 0;

  array_mul_arbiter #(
    .k (K)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_x     (req0_x),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_x     (req1_x),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between grants.
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
    nChecks++;
    if (act !== expVal) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expVal);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [K-1:0] a0, input logic [K-1:0] x0,
                               input logic v1, input logic [K-1:0] a1, input logic [K-1:0] x1);
    req0_valid = v0;
    req0_a     = a0;
    req0_x     = x0;
    req1_valid = v1;
    req1_a     = a1;
    req1_x     = x1;
  endtask

  task automatic waitAccept(input logic who);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = who ? req1_ready : req0_ready;
    end
    checkOutput(who ? "accept_req1" : "accept_req0", 32'(seen), 32'd1);
  endtask

  task automatic waitRspValid();
    for (int n = 0; n < 20 && !rsp_valid; n++) begin
      @(negedge clk);
    end
    checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic waitRespCount(input int target);
    for (int n = 0; n < 60 && respCount < target; n++) begin
      @(posedge clk);
    end
    checkOutput("rsp_count", respCount, target);
  endtask

  task automatic issueSingle(input logic id, input logic [K-1:0] a, input logic [K-1:0] x,
                             input logic [2*K-1:0] expVal);
    int target;
    target = respCount + 1;
    sbQ.push_back('{id: id, result: expVal});
    @(posedge clk);
    #1;
    if (id) applyStimulus(1'b0, '0, '0, 1'b1, a, x);
    else    applyStimulus(1'b1, a, x, 1'b0, '0, '0);
    waitAccept(id);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    waitRespCount(target);
  endtask

  // Monitor: every response handshake is compared against the queue head,
  // and the two ready outputs are never allowed high together.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpected_rsp: got result %0d id %0d, expected no response", rsp_result, rsp_id);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rsp_result", 32'(rsp_result), 32'(e.result));
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
      end
      respCount++;
    end
    if (rst_n) begin
      checkOutput("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
    end
  end

  // Directed stimulus sequence.
  initial begin
    int base;
    int accCycle[4];
    logic seen;

    applyStimulus(1'b1, 8'd5, 8'd6, 1'b1, 8'd7, 8'd8);
    rsp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state, with both requesters pending during reset.
    repeat (2) @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #2 rst_n = 1'b1;

    // Single request 1*1 on requester 0, cycle by cycle.
    sbQ.push_back('{id: 1'b0, result: 16'd1});
    @(posedge clk);
    #1 applyStimulus(1'b1, 8'd1, 8'd1, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t1_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("t1_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("t1_calc_ready", 32'(req0_ready), 32'd0);
    checkOutput("t1_calc_busy", 32'(busy), 32'd1);
    checkOutput("t1_calc_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_resp_valid", 32'(rsp_valid), 32'd1);
    waitRespCount(1);

    // Boundary products.
    issueSingle(1'b0, 8'd0, 8'd255, 16'd0);
    issueSingle(1'b1, 8'd255, 8'd1, 16'd255);
    issueSingle(1'b0, 8'd15, 8'd1, 16'd15);

    // Backpressure with 255*255, requester 1 waiting with changing operands.
    base = respCount;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    sbQ.push_back('{id: 1'b0, result: 16'd65025});
    sbQ.push_back('{id: 1'b1, result: 16'd21});
    applyStimulus(1'b1, 8'd255, 8'd255, 1'b0, '0, '0);
    waitAccept(1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, '0, 1'b1, 8'd3, 8'd7);
    waitRspValid();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_result", 32'(rsp_result), 32'd65025);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("bp_req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      req1_a = 8'(100 + i);
      req1_x = 8'(200 - i);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req1_a    = 8'd3;
    req1_x    = 8'd7;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_consume_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_consume_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp_next_req1_ready", 32'(req1_ready), 32'd1);
    checkOutput("bp_next_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    waitRespCount(base + 2);

    // Reset while a response is held, then contention from a clean start.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    applyStimulus(1'b1, 8'd9, 8'd9, 1'b0, '0, '0);
    waitAccept(1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b1, 8'd170, 8'd85, 1'b1, 8'd240, 8'd15);
    waitRspValid();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mr_rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("mr_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("mr_busy", 32'(busy), 32'd0);
    checkOutput("mr_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("mr_req1_ready", 32'(req1_ready), 32'd0);
    rsp_ready = 1'b1;
    base = respCount;
    sbQ.push_back('{id: 1'b0, result: 16'd14450});
    sbQ.push_back('{id: 1'b1, result: 16'd3600});
    sbQ.push_back('{id: 1'b0, result: 16'd14450});
    sbQ.push_back('{id: 1'b1, result: 16'd3600});
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      seen = 1'b0;
      for (int n = 0; n < 12 && !seen; n++) begin
        @(negedge clk);
        seen = req0_ready | req1_ready;
      end
      checkOutput("rr_accept_seen", 32'(seen), 32'd1);
      accCycle[a] = cycle;
      checkOutput("rr_grant_id", 32'(req1_ready), 32'(a % 2));
      if (a > 0) begin
        checkOutput("rr_accept_spacing", accCycle[a] - accCycle[a-1], 32'd3);
      end
      @(posedge clk);
    end
    #1 applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    waitRespCount(base + 4);

    repeat (3) @(posedge clk);
    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
